led_matrix_scanner: RTL

- Time-multiplexed LED matrix driver: scans one column at a time from a registered frame buffer. Per-column dwell with PWM brightness and inter-column blanking.
- Non-square ROWSxCOLS supported. A double-buffered frame load handshake means a new frame never tears mid-scan.
- Sits between the Conway game-of-life core (frame producer) and the LED matrix pins.

---
 rtl/led_matrix_scanner.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/led_matrix_scanner.sv
// LED matrix column scanner with PWM dwell and double-buffered frame load.
// Optional inter-column blanking is compiled in with `define LED_SCAN_BLANKING_EN.
// Outputs are decoded from registered state only.
module led_matrix_scanner #(
  parameter int ROWS        = 8,
  parameter int COLS        = 8,
  parameter int PWM_BITS    = 3,
  parameter int PRESCALE    = 1,
  parameter int BLANK_TICKS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic [ROWS*COLS-1:0]     cells,
  input  logic                     cells_valid,
  output logic                     cells_ready,
  input  logic [PWM_BITS-1:0]      brightness,
  output logic [ROWS-1:0]          rows,
  output logic [COLS-1:0]          cols,
  output logic [$clog2(COLS):0]    col_idx,
  output logic                     frame_done
);

  localparam int CIW = $clog2(COLS) + 1;
  localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PWM_BITS-1:0] DW_ONE  = 1;
  localparam logic [CIW-1:0]      COL_ONE = 1;
  localparam logic [PSW-1:0]      PS_ONE  = 1;
  localparam logic [CIW-1:0]      COL_LAST = CIW'(COLS - 1);
  localparam logic [PSW-1:0]      PS_LAST  = PSW'(PRESCALE - 1);

  if (ROWS < 1 || ROWS > 16) begin : g_bad_rows
    $error("led_matrix_scanner: ROWS must be in 1..16");
  end
  if (COLS < 1 || COLS > 16) begin : g_bad_cols
    $error("led_matrix_scanner: COLS must be in 1..16");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("led_matrix_scanner: PRESCALE must be >= 1");
  end
  if (PWM_BITS < 1) begin : g_bad_pwm
    $error("led_matrix_scanner: PWM_BITS must be >= 1");
  end
  if (BLANK_TICKS < 1) begin : g_bad_blank
    $error("led_matrix_scanner: BLANK_TICKS must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    BLANK = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CIW-1:0]        col_q, col_d;
  logic [PWM_BITS-1:0]   dwell_q, dwell_d;
  logic [PWM_BITS-1:0]   bright_q, bright_d;
  logic [PSW-1:0]        presc_q, presc_d;
  logic                  fdone_q, fdone_d;
  logic [ROWS*COLS-1:0]  active_q, shadow_q;
  logic                  pending_q;
  logic                  tick;
  logic                  swap;
  logic                  col_end;
  logic                  lit;

`ifdef LED_SCAN_BLANKING_EN
  localparam int BTW = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS) : 1;
  localparam logic [BTW-1:0] BL_ONE  = 1;
  localparam logic [BTW-1:0] BL_LAST = BTW'(BLANK_TICKS - 1);
  logic [BTW-1:0] blank_q, blank_d;
`endif

  assign tick = (presc_q == PS_LAST);

  // Next-state logic: dwell/blank sequencing, column advance and buffer swap request
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    dwell_d  = dwell_q;
    bright_d = bright_q;
    presc_d  = tick ? '0 : presc_q + PS_ONE;
    fdone_d  = 1'b0;
    col_end  = 1'b0;
    swap     = (state_q == IDLE) && pending_q;
`ifdef LED_SCAN_BLANKING_EN
    blank_d  = blank_q;
`endif
    if (!ena) begin
      state_d = IDLE;
      col_d   = '0;
      dwell_d = '0;
      presc_d = '0;
`ifdef LED_SCAN_BLANKING_EN
      blank_d = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = SCAN;
          col_d    = '0;
          dwell_d  = '0;
          presc_d  = '0;
          bright_d = brightness;
        end
        SCAN: begin
          if (tick) begin
            dwell_d = dwell_q + DW_ONE;
            if (dwell_q == '1) begin
`ifdef LED_SCAN_BLANKING_EN
              state_d = BLANK;
              blank_d = '0;
`else
              col_end = 1'b1;
`endif
            end
          end
        end
        BLANK: begin
`ifdef LED_SCAN_BLANKING_EN
          if (tick) begin
            if (blank_q == BL_LAST) col_end = 1'b1;
            else                    blank_d = blank_q + BL_ONE;
          end
`else
          state_d = IDLE;
`endif
        end
        default: state_d = IDLE;
      endcase
      // Shared column-start path; the frame boundary also wraps, pulses and swaps
      if (col_end) begin
        state_d  = SCAN;
        dwell_d  = '0;
        presc_d  = '0;
        bright_d = brightness;
        if (col_q == COL_LAST) begin
          col_d   = '0;
          fdone_d = 1'b1;
          swap    = pending_q;
        end else begin
          col_d   = col_q + COL_ONE;
        end
      end
    end
  end

  // Scan state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      col_q    <= '0;
      dwell_q  <= '0;
      bright_q <= '0;
      presc_q  <= '0;
      fdone_q  <= 1'b0;
`ifdef LED_SCAN_BLANKING_EN
      blank_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      dwell_q  <= dwell_d;
      bright_q <= bright_d;
      presc_q  <= presc_d;
      fdone_q  <= fdone_d;
`ifdef LED_SCAN_BLANKING_EN
      blank_q  <= blank_d;
`endif
    end
  end

  // Frame buffers: capture into shadow on handshake, promote to active on swap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
    end else if (swap) begin
      active_q  <= shadow_q;
      pending_q <= 1'b0;
    end else if (cells_valid && !pending_q) begin
      shadow_q  <= cells;
      pending_q <= 1'b1;
    end
  end

  // Pin decode from registered state: one-hot column, active-low rows gated by PWM
  always_comb begin
    rows = '1;
    cols = '0;
    lit  = (dwell_q < bright_q);
    for (int unsigned c = 0; c < COLS; c++) begin
      if (state_q == SCAN && col_q == CIW'(c)) begin
        cols[c] = 1'b1;
        for (int unsigned r = 0; r < ROWS; r++) begin
          rows[r] = ~(active_q[r*COLS + c] & lit);
        end
      end
    end
  end

  assign col_idx     = col_q;
  assign frame_done  = fdone_q;
  assign cells_ready = ~pending_q;

endmodule
